// File: rtl/nt_lane_scheduler_if.sv
// Lane-side and counter-side signals of the shared-counter lane scheduler.
//
// Handshake: a lane raises req (level) and holds it; gnt[id] answers one cycle
// later and stays high until the session ends. The session ends with exactly one
// of done[id] (result/result_id valid that cycle) or err (result_id valid,
// result unchanged), each a single-cycle pulse. The lane may drop req once it
// sees that pulse. Dropping req early while granted aborts the session.
interface nt_lane_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ser_in;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic               err;
    logic [7:0]         result;
    logic [IDW-1:0]     result_id;
    logic               busy;
    logic               ctr_en;
    logic               ctr_ser;
    logic               ctr_valid;
    logic [7:0]         ctr_nt;

    // Lanes plus counter, as seen from outside the scheduler.
    modport master (
        output req, ser_in, ctr_valid, ctr_nt,
        input  gnt, done, err, result, result_id, busy, ctr_en, ctr_ser
    );

    // The scheduler itself.
    modport slave (
        input  req, ser_in, ctr_valid, ctr_nt,
        output gnt, done, err, result, result_id, busy, ctr_en, ctr_ser
    );
endinterface

// File: rtl/nt_lane_scheduler.sv
// Round-robin scheduler sharing one serial-in counter among NUM_REQ lanes.
// The granted lane's serial bit is forwarded to the counter while its enable
// is held high; the counter's valid result is captured and tagged with the
// lane id. A watchdog aborts sessions that never produce a result, and a cool
// period with the enable low lets the counter clear between sessions.
module nt_lane_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nt_lane_scheduler_if.slave   bus,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4,
        S_COOL  = 3'd5
    } state_t;

    state_t             state;
    logic [IDW-1:0]     id;
    logic [IDW-1:0]     ptr;
    logic [15:0]        wd;
    logic [15:0]        cool;

    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] done_r;
    logic               err_r;
    logic [7:0]         result_r;
    logic [IDW-1:0]     result_id_r;
    logic               busy_r;
    logic               ctr_en_r;
    logic               ctr_ser_r;

    logic               pick_valid;
    logic [IDW-1:0]     pick_id;
    logic [IDW:0]       scan;

    // Scan requests from the pointer upward with wrap; scanning the offsets in
    // reverse lets the smallest offset win.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        scan       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan = {1'b0, ptr} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NUM_REQ)) begin
                scan = scan - (IDW+1)'(NUM_REQ);
            end
            if (bus.req[scan[IDW-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = scan[IDW-1:0];
            end
        end
    end

    // Session FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            id          <= '0;
            ptr         <= '0;
            wd          <= '0;
            cool        <= '0;
            gnt_r       <= '0;
            done_r      <= '0;
            err_r       <= 1'b0;
            result_r    <= '0;
            result_id_r <= '0;
            busy_r      <= 1'b0;
            ctr_en_r    <= 1'b0;
            ctr_ser_r   <= 1'b1;
        end else begin
            done_r <= '0;
            err_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state  <= S_GRANT;
                        id     <= pick_id;
                        gnt_r  <= NUM_REQ'(1) << pick_id;
                        busy_r <= 1'b1;
                        wd     <= '0;
                    end
                end
                S_GRANT: begin
                    state     <= S_RUN;
                    wd        <= '0;
                    ctr_en_r  <= 1'b1;
                    ctr_ser_r <= bus.ser_in[id];
                end
                S_RUN: begin
                    // A valid result wins over a request drop or a timeout.
                    if (bus.ctr_valid) begin
                        state       <= S_DONE;
                        result_r    <= bus.ctr_nt;
                        result_id_r <= id;
                        done_r      <= NUM_REQ'(1) << id;
                        ctr_en_r    <= 1'b0;
                        ctr_ser_r   <= 1'b1;
                    end else if (!bus.req[id] || (wd == 16'(TIMEOUT - 1))) begin
                        state       <= S_ABORT;
                        result_id_r <= id;
                        err_r       <= 1'b1;
                        ctr_en_r    <= 1'b0;
                        ctr_ser_r   <= 1'b1;
                    end else begin
                        wd        <= wd + 16'd1;
                        ctr_ser_r <= bus.ser_in[id];
                    end
                end
                S_DONE, S_ABORT: begin
                    state <= S_COOL;
                    gnt_r <= '0;
                    cool  <= '0;
                    ptr   <= (id == IDW'(NUM_REQ - 1)) ? '0 : id + IDW'(1);
                end
                S_COOL: begin
                    if (cool == 16'(GAP - 1)) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        cool <= cool + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.result    = result_r;
    assign bus.result_id = result_id_r;
    assign bus.busy      = busy_r;
    assign bus.ctr_en    = ctr_en_r;
    assign bus.ctr_ser   = ctr_ser_r;
    assign state_dbg     = state;

endmodule

// File: tb/tb_nt_lane_scheduler.sv
// Bench for nt_lane_scheduler: a behavioural counter stand-in answers the
// enable, a scoreboard queue holds the expected {err, id, result} of every
// session end, and directed scenarios cover arbitration, timing and aborts.
module tb_nt_lane_scheduler;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 8;
    localparam int GAP     = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    nt_lane_scheduler_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

    nt_lane_scheduler #(
        .NUM_REQ(NUM_REQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .GAP(GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];

    int          model_len = 0;
    logic [7:0]  model_nt = 8'h00;
    logic        stray = 1'b0;
    int          en_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counter stand-in: after model_len cycles of enable, presents one valid
    // cycle carrying model_nt; ctr_nt carries junk otherwise.
    initial begin
        bus.ctr_valid = 1'b0;
        bus.ctr_nt    = 8'hEE;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ctr_en) en_cnt++;
            else            en_cnt = 0;
            bus.ctr_valid = stray || (bus.ctr_en && model_len != 0 && en_cnt == model_len);
            bus.ctr_nt    = bus.ctr_valid ? (stray ? 8'hBB : model_nt) : 8'hEE;
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [10:0] exp_v;
        logic [10:0] act_v;
        logic [3:0]  exp_done;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.err || (|bus.done))) begin
                checks++;
                act_v = {bus.err, bus.result_id, bus.result};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_end: got err=%0b done=%b id=%0d result=%0h with nothing expected",
                             bus.err, bus.done, bus.result_id, bus.result);
                end else begin
                    exp_v    = exp_q.pop_front();
                    exp_done = exp_v[10] ? 4'b0000 : (4'b0001 << exp_v[9:8]);
                    if (act_v !== exp_v || bus.done !== exp_done) begin
                        errors++;
                        $display("FAIL session_end: got err=%0b id=%0d result=%0h done=%b expected err=%0b id=%0d result=%0h done=%b",
                                 act_v[10], act_v[9:8], act_v[7:0], bus.done,
                                 exp_v[10], exp_v[9:8], exp_v[7:0], exp_done);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.ser_in = '1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic [3:0] exp_gnt, output int lat, output int en_seen);
        lat     = 0;
        en_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            lat++;
            if (|bus.gnt) break;
            if (bus.ctr_en) en_seen++;
        end
        check("grant", bus.gnt, exp_gnt);
    endtask

    task automatic wait_end(output int run_cycles);
        run_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if ((|bus.done) || bus.err) break;
            if (bus.ctr_en) run_cycles++;
        end
        check("session_end_seen", ((|bus.done) || bus.err) ? 1 : 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            step();
        end
        check("idle_reached", bus.busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no completion expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int         lat;
        int         en_seen;
        int         runc;
        logic [5:0] pat;

        bus.req    = '0;
        bus.ser_in = '1;
        rst_n      = 1'b0;
        #1;
        step();
        // Reset state.
        check("rst_state", state_dbg, 3'd0);
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_flags", {bus.done, bus.err, bus.busy, bus.ctr_en, bus.ctr_ser}, 8'b0000_0001);
        check("rst_result", {bus.result_id, bus.result}, 10'h000);
        step();
        rst_n = 1'b1;

        // A valid from the counter outside RUN must be ignored.
        stray = 1'b1;
        step();
        step();
        stray = 1'b0;
        step();
        check("stray_valid_result", bus.result, 8'h00);
        check("stray_valid_idle", bus.busy, 0);

        // T1: single lane, serial bits forwarded with one cycle of lag.
        pat       = 6'b011001;
        model_len = 6;
        model_nt  = 8'h03;
        exp_q.push_back({1'b0, 2'd0, 8'h03});
        bus.req = 4'b0001;
        step();
        check("t1_gnt", bus.gnt, 4'b0001);
        check("t1_en_in_grant", bus.ctr_en, 0);
        bus.ser_in[0] = pat[0];
        for (int j = 1; j <= 6; j++) begin
            step();
            check("t1_en_run", bus.ctr_en, 1);
            check("t1_ser", bus.ctr_ser, pat[j-1]);
            if (j < 6) bus.ser_in[0] = pat[j];
        end
        step();
        check("t1_done", bus.done, 4'b0001);
        check("t1_en_off", {bus.ctr_en, bus.ctr_ser}, 2'b01);
        bus.req    = '0;
        bus.ser_in = '1;
        step();
        check("t1_gnt_drop", bus.gnt, 4'b0000);
        wait_idle();

        // T2: contention, lane1 -> lane3 -> lane1 with a fixed cool gap.
        do_reset();
        model_len = 3;
        model_nt  = 8'h5A;
        exp_q.push_back({1'b0, 2'd1, 8'h5A});
        exp_q.push_back({1'b0, 2'd3, 8'h5A});
        exp_q.push_back({1'b0, 2'd1, 8'h5A});
        bus.req = 4'b1010;
        wait_grant(4'b0010, lat, en_seen);
        check("t2_first_lat", lat, 1);
        wait_end(runc);
        check("t2_run1", runc, 3);
        wait_grant(4'b1000, lat, en_seen);
        check("t2_gap1", lat, GAP + 2);
        check("t2_en_low1", en_seen, 0);
        wait_end(runc);
        wait_grant(4'b0010, lat, en_seen);
        check("t2_gap2", lat, GAP + 2);
        check("t2_en_low2", en_seen, 0);
        wait_end(runc);
        bus.req = '0;
        wait_idle();

        // T3: watchdog abort after TIMEOUT run cycles; result held; pointer moves on.
        model_len = 0;
        exp_q.push_back({1'b1, 2'd2, 8'h5A});
        bus.req = 4'b0100;
        wait_grant(4'b0100, lat, en_seen);
        wait_end(runc);
        check("t3_run_cycles", runc, TIMEOUT);
        check("t3_err", bus.err, 1);
        check("t3_result_held", bus.result, 8'h5A);
        bus.req = '0;
        wait_idle();
        model_len = 2;
        model_nt  = 8'h3C;
        exp_q.push_back({1'b0, 2'd0, 8'h3C});
        bus.req = 4'b0101;
        wait_grant(4'b0001, lat, en_seen);
        wait_end(runc);
        bus.req = '0;
        wait_idle();

        // T4: request drop in RUN cycle 3 aborts; drop together with valid completes.
        do_reset();
        model_len = 0;
        exp_q.push_back({1'b1, 2'd2, 8'h00});
        bus.req = 4'b0100;
        wait_grant(4'b0100, lat, en_seen);
        step();
        step();
        step();
        bus.req[2] = 1'b0;
        step();
        check("t4_err", {bus.err, bus.result_id}, 3'b110);
        wait_idle();
        model_len = 3;
        model_nt  = 8'hA7;
        exp_q.push_back({1'b0, 2'd2, 8'hA7});
        bus.req = 4'b0100;
        wait_grant(4'b0100, lat, en_seen);
        step();
        step();
        step();
        bus.req[2] = 1'b0;
        step();
        check("t4_same_cycle", {bus.done, bus.err}, 5'b0100_0);
        wait_idle();

        // T5: reset in the middle of RUN; pointer returns to lane 0.
        model_len = 0;
        bus.req   = 4'b1010;
        wait_grant(4'b1000, lat, en_seen);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t5_async_outputs", {bus.ctr_en, bus.gnt, bus.busy, bus.ctr_ser}, 7'b0_0000_0_1);
        check("t5_result_cleared", bus.result, 8'h00);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_len = 2;
        model_nt  = 8'h81;
        exp_q.push_back({1'b0, 2'd1, 8'h81});
        wait_grant(4'b0010, lat, en_seen);
        wait_end(runc);
        bus.req = '0;
        wait_idle();

        // T6: back-to-back sessions on lane 0, then pointer wrap 3 -> 0.
        do_reset();
        model_len = 1;
        model_nt  = 8'h11;
        exp_q.push_back({1'b0, 2'd0, 8'h11});
        exp_q.push_back({1'b0, 2'd0, 8'h22});
        bus.req = 4'b0001;
        wait_grant(4'b0001, lat, en_seen);
        wait_end(runc);
        check("t6_run1", runc, 1);
        model_nt = 8'h22;
        wait_grant(4'b0001, lat, en_seen);
        check("t6_gap", lat, GAP + 2);
        wait_end(runc);
        bus.req = '0;
        wait_idle();
        model_nt = 8'h33;
        exp_q.push_back({1'b0, 2'd3, 8'h33});
        exp_q.push_back({1'b0, 2'd0, 8'h44});
        bus.req = 4'b1001;
        wait_grant(4'b1000, lat, en_seen);
        wait_end(runc);
        model_nt = 8'h44;
        wait_grant(4'b0001, lat, en_seen);
        wait_end(runc);
        bus.req = '0;
        wait_idle();

        step();
        step();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
